uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Transmit-side buffer placed directly upstream of the UART transmitter. It accepts data words from the system at clock rate and stores up to DEPTH of them. It then feeds them one frame at a time to the transmitter through the `tx_start` / `tx_data` / `tx_done` handshake. This decouples bursty producers from the baud-limited serial line, so software never has to poll `tx_done` per word.

## Interface
- `DATA_LEN`, default 8: word width; must equal the transmitter's `data_len`.
- `DEPTH`, default 16: FIFO entries; power of two, ≥ 2.
- `clk`  input  1  system clock, shared with the UART core.
- `rst`  input  1  asynchronous, active-low reset.
- `wr_en`  input  1  write request; sampled on rising `clk`.
- `wr_data`  input  DATA_LEN  word to enqueue.
- `flush`  input  1  synchronous clear of stored (not yet started) words.
- `full`  output  1  count == DEPTH.
- `empty`  output  1  count == 0.
- `count`  output  $clog2(DEPTH+1)  number of stored words, excluding the word in flight.
- `overflow`  output  1  sticky; set on a write while full.
- `busy`  output  1  a frame is started or in flight (state ≠ IDLE).
- `tx_start`  output  1  one-cycle start pulse to the transmitter.
- `tx_data`  output  DATA_LEN  word to the transmitter; stable from `tx_start` until `tx_done`.
- `tx_done`  input  1  one-cycle completion pulse from the transmitter.

## Operation
- Storage: DEPTH×DATA_LEN array with wr_ptr and rd_ptr of width $clog2(DEPTH). Pointers wrap modulo DEPTH. `count` is tracked separately; full/empty derive from `count`.
- Write: `wr_en` && !full stores `wr_data` at wr_ptr, then wr_ptr+1 and count+1.
- Rejected write: `wr_en` && full drops the word, sets `overflow`, and leaves count and wr_ptr unchanged. This applies even if a pop happens in the same cycle.
- `overflow` clears only on reset.
- FSM states:
  - IDLE: if count ≠ 0, pop the head into the `tx_data` register, pulse `tx_start` and go to START. Otherwise stay in IDLE.
  - START: `tx_start` is high for exactly this cycle. Go to WAIT_DONE unconditionally.
  - WAIT_DONE: hold `tx_data` and wait for `tx_done`. On `tx_done`:
    - if count ≠ 0 (after same-cycle updates are excluded), pop the next word and go to START;
    - otherwise go to IDLE.
- `tx_done` seen in IDLE or START is ignored.
- Simultaneous write and pop in one cycle: count is unchanged, both pointers advance. A write into an empty FIFO is not popped in the same cycle.
- `flush`: sets rd_ptr = wr_ptr and count = 0. It does not clear `overflow` and does not abort the frame in flight; the FSM still waits for `tx_done`. A write in the same cycle as `flush` is discarded, without setting `overflow`.
- Reset asserted at any time: all state returns to reset values immediately. The in-flight frame is abandoned and a `tx_done` arriving after reset release is ignored.
- Width rules: count arithmetic is in $clog2(DEPTH+1) bits and never exceeds DEPTH or goes below 0.

## Timing
- Reset values: `tx_start`=0, `tx_data`=0, `full`=0, `empty`=1, `count`=0, `overflow`=0, `busy`=0; FSM in IDLE; pointers 0.
- All outputs are registered; no combinational path from inputs to outputs.
- First word into an idle, empty block:
  - `wr_en` sampled at edge N makes `empty` go low after edge N.
  - Pop happens at edge N+1; `tx_start` is high in cycle N+1…N+2 with `tx_data` valid.
  - `count` returns to 0 after edge N+1.
- Back-to-back: `tx_done` sampled at edge M with data pending gives `tx_start` high after edge M and a new `tx_data`. The transmitter sees no idle cycle beyond its own stop bit.
- `tx_data` changes only at a pop edge.
- `busy` rises with `tx_start` and falls on the edge that returns the FSM to IDLE.

## Test plan
- Reset: hold `rst`=0 with random inputs. Required: `empty`=1, `count`=0, `tx_start`=0, `tx_data`=0, `busy`=0 throughout.
- Single word: write 0xA5 at edge N. Required: `tx_start` is a one-cycle pulse after edge N+1 with `tx_data`=0xA5, and `tx_data` holds 0xA5 until `tx_done`. After `tx_done`: `busy`=0 and `empty`=1.
- Burst and order: with DEPTH=16, write 0x00…0x10 (17 words) with the first frame not yet done. Required:
  - `tx_data` carries 0x00 in flight;
  - `full`=1 after the 17th write and `overflow` stays 0;
  - draining via `tx_done` delivers 0x01…0x10 in order, with `tx_start` exactly one cycle after each `tx_done`.
- Overflow: with the block full and a frame in flight, write 0xFF. Required: `overflow`=1 (sticky), `count`=16, and 0xFF is never transmitted.
- Simultaneous write/pop and wrap: keep count ≈ 1 across 40 frames so the pointers wrap twice, writing on the same edge as each `tx_done`. Required: `count` is stable, no words are lost or duplicated, and order is preserved.
- Flush and reset mid-frame:
  - `flush` with 5 words stored and a frame in flight: `count`=0, the in-flight `tx_data` is held, and `busy` stays 1 until `tx_done`.
  - `rst` pulsed mid-frame: all outputs return to reset values, and a later stray `tx_done` produces no `tx_start`.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// Transmit-side buffer that sits directly in front of the UART transmitter.
// Words written at clock rate are queued, up to DEPTH of them. The queue is
// drained one frame at a time through the tx_start / tx_data / tx_done
// handshake, so a bursty producer never has to poll tx_done for each word.
//
// Parameters
//   DATA_LEN  word width; must match the transmitter's data length
//   DEPTH     number of FIFO entries (power of two, >= 2)
//
// Ports
//   clk       system clock, shared with the UART core
//   rst       asynchronous, active-low reset
//   wr_en     write request
//   wr_data   word to enqueue
//   flush     synchronous discard of stored (not yet started) words
//   full      count == DEPTH
//   empty     count == 0
//   count     stored words, not counting the word in flight
//   overflow  sticky flag: a write arrived while full (cleared by reset only)
//   busy      a frame has been started and is not yet finished
//   tx_start  one-cycle start pulse to the transmitter
//   tx_data   word to the transmitter, stable from tx_start until tx_done
//   tx_done   one-cycle completion pulse from the transmitter
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DATA_LEN = 8,
    parameter int DEPTH    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_LEN-1:0]        wr_data,
    input  logic                       flush,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       busy,
    output logic                       tx_start,
    output logic [DATA_LEN-1:0]        tx_data,
    input  logic                       tx_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [DATA_LEN-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                is_full;
    logic                can_pop;
    logic                do_pop;
    logic                do_wr;
    logic                wr_rejected;
    logic [CW-1:0]       count_next;

    // Next-state and datapath control. Pop decisions look only at the count
    // held at the start of the cycle, so a word written into an empty FIFO
    // is never popped on the same edge. Flush wins over both write and pop.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_next  = state;
        do_pop      = 1'b0;
        is_full     = (count == CW'(DEPTH));
        can_pop     = !flush && (count != '0);
        do_wr       = wr_en && !flush && !is_full;
        wr_rejected = wr_en && !flush && is_full;

        case (state)
            IDLE: begin
                if (can_pop) begin
                    do_pop     = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    if (can_pop) begin
                        do_pop     = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (flush) begin
            count_next = '0;
        end else begin
            case ({do_wr, do_pop})
                2'b10:   count_next = count + CW'(1);
                2'b01:   count_next = count - CW'(1);
                default: count_next = count;
            endcase
        end
    end

    // Control state and all registered outputs. Status flags are computed
    // from the next-state values so they are true flops, not decodes.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
            busy     <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            full     <= (count_next == CW'(DEPTH));
            empty    <= (count_next == '0);
            busy     <= (state_next != IDLE);
            tx_start <= (state_next == START);

            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end

            // Flush drops everything still queued but leaves the word in
            // flight (already copied into tx_data) untouched.
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            if (do_pop) begin
                tx_data <= mem[rd_ptr];
            end

            if (wr_rejected) begin
                overflow <= 1'b1;
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; entries are only
    // ever read after being written, and leaving reset off lets it map to RAM.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Self-checking bench for uart_tx_fifo (DATA_LEN=8, DEPTH=16). A reference
// model built from a word queue and a three-phase frame tracker (idle /
// start pulse / waiting for done) predicts every output each cycle. Each
// scenario task drives stimulus and compares inline, both against the model
// and against fixed values for the key points of each scenario.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int DATA_LEN = 8;
    localparam int DEPTH    = 16;
    localparam int CW       = $clog2(DEPTH + 1);
    localparam int VW       = DATA_LEN + CW + 5;

    logic                clk     = 1'b0;
    logic                rst     = 1'b0;
    logic                wr_en   = 1'b0;
    logic [DATA_LEN-1:0] wr_data = '0;
    logic                flush   = 1'b0;
    logic                tx_done = 1'b0;
    logic                full;
    logic                empty;
    logic [CW-1:0]       count;
    logic                overflow;
    logic                busy;
    logic                tx_start;
    logic [DATA_LEN-1:0] tx_data;

    int errors = 0;
    int checks = 0;

    uart_tx_fifo #(
        .DATA_LEN(DATA_LEN),
        .DEPTH   (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .flush   (flush),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .overflow(overflow),
        .busy    (busy),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: stored words in a queue, the frame phase as
    // 0 = idle, 1 = start pulse, 2 = waiting for done.
    // ------------------------------------------------------------------
    logic [DATA_LEN-1:0] m_q[$];
    int                  m_phase = 0;
    logic [DATA_LEN-1:0] m_data  = '0;
    logic                m_ovf   = 1'b0;

    task automatic model_reset();
        m_q.delete();
        m_phase = 0;
        m_data  = '0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_edge();
        int   n;
        logic pop;
        n   = m_q.size();
        pop = !flush && (n != 0) && (m_phase == 0 || (m_phase == 2 && tx_done));
        if (pop) m_data = m_q.pop_front();
        if (wr_en && !flush) begin
            if (n == DEPTH) m_ovf = 1'b1;
            else            m_q.push_back(wr_data);
        end
        if (flush) m_q.delete();
        case (m_phase)
            0:       m_phase = pop ? 1 : 0;
            1:       m_phase = 2;
            default: if (tx_done) m_phase = pop ? 1 : 0;
        endcase
    endtask

    function automatic logic [VW-1:0] exp_vec();
        return {(m_phase != 0), (m_phase == 1), m_data, CW'(m_q.size()),
                (m_q.size() == DEPTH), (m_q.size() == 0), m_ovf};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {busy, tx_start, tx_data, count, full, empty, overflow};
    endfunction

    // One clock edge: the model sees the same inputs the DUT samples.
    task automatic step();
        @(posedge clk);
        if (!rst) model_reset();
        else      model_edge();
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_en   = 1'($urandom);
            wr_data = DATA_LEN'($urandom);
            flush   = 1'($urandom);
            tx_done = 1'($urandom);
            step();
            checks++;
            if ({empty, count, tx_start, tx_data, busy, full, overflow} !==
                {1'b1, CW'(0), 1'b0, DATA_LEN'(0), 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_hold: got %h, expected reset values", dut_vec());
            end
        end
        wr_en = 1'b0; flush = 1'b0; tx_done = 1'b0;
        rst = 1'b1;
        step();
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_release: got %h, expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_single_word();
        wr_en = 1'b1; wr_data = 8'hA5;
        step();
        wr_en = 1'b0;
        checks++;
        if (empty !== 1'b0 || count !== CW'(1) || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL single_written: empty=%b count=%0d tx_start=%b, expected 0 1 0",
                     empty, count, tx_start);
        end
        step();
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'hA5 || count !== CW'(0) || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_start: tx_start=%b tx_data=%h count=%0d busy=%b, expected 1 a5 0 1",
                     tx_start, tx_data, count, busy);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (tx_start !== 1'b0 || tx_data !== 8'hA5 || dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single_hold: got %h, expected %h", dut_vec(), exp_vec());
            end
        end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || empty !== 1'b1 || tx_start !== 1'b0 || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL single_done: got %h, expected %h", dut_vec(), exp_vec());
        end
    endtask

    // Writes 0x00..0x10 one per cycle while the first frame stays in flight.
    task automatic test_burst();
        for (int i = 0; i <= DEPTH; i++) begin
            wr_en   = 1'b1;
            wr_data = DATA_LEN'(i);
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL burst_fill[%0d]: got %h, expected %h", i, dut_vec(), exp_vec());
            end
        end
        wr_en = 1'b0;
        checks++;
        if (tx_data !== 8'h00 || full !== 1'b1 || overflow !== 1'b0 || count !== CW'(DEPTH)) begin
            errors++;
            $display("FAIL burst_full: tx_data=%h full=%b overflow=%b count=%0d, expected 00 1 0 16",
                     tx_data, full, overflow, count);
        end
    endtask

    task automatic test_overflow();
        wr_en = 1'b1; wr_data = 8'hFF;
        step();
        wr_en = 1'b0;
        step();
        checks++;
        if (overflow !== 1'b1 || count !== CW'(DEPTH) || full !== 1'b1 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL overflow_set: overflow=%b count=%0d full=%b tx_data=%h, expected 1 16 1 00",
                     overflow, count, full, tx_data);
        end
    endtask

    // Drains the burst: 0x01..0x10 in order, each start one cycle after done.
    task automatic test_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            repeat (2) step();
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
            checks++;
            if (tx_start !== 1'b1 || tx_data !== DATA_LEN'(i) || overflow !== 1'b1 ||
                dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL drain_order[%0d]: tx_start=%b tx_data=%h overflow=%b, expected 1 %h 1",
                         i, tx_start, tx_data, overflow, DATA_LEN'(i));
            end
        end
        repeat (2) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (tx_start !== 1'b0 || busy !== 1'b0 || empty !== 1'b1 || tx_data !== 8'h10) begin
                errors++;
                $display("FAIL drain_idle: tx_start=%b busy=%b empty=%b tx_data=%h, expected 0 0 1 10",
                         tx_start, busy, empty, tx_data);
            end
            step();
        end
    endtask

    // Count held at 1 for 40 frames with a write on every tx_done edge.
    task automatic test_wrap();
        logic [DATA_LEN-1:0] sb[$];
        logic [DATA_LEN-1:0] w;
        logic [DATA_LEN-1:0] want;
        w = DATA_LEN'($urandom); sb.push_back(w);
        wr_en = 1'b1; wr_data = w;
        step();
        w = DATA_LEN'($urandom); sb.push_back(w);
        wr_data = w;
        step();
        wr_en = 1'b0;
        want = sb.pop_front();
        checks++;
        if (tx_start !== 1'b1 || tx_data !== want || count !== CW'(1)) begin
            errors++;
            $display("FAIL wrap_first: tx_start=%b tx_data=%h count=%0d, expected 1 %h 1",
                     tx_start, tx_data, count, want);
        end
        step();
        for (int k = 0; k < 40; k++) begin
            step();
            tx_done = 1'b1; wr_en = 1'b1;
            w = DATA_LEN'($urandom); sb.push_back(w);
            wr_data = w;
            step();
            tx_done = 1'b0; wr_en = 1'b0;
            want = sb.pop_front();
            checks++;
            if (tx_start !== 1'b1 || tx_data !== want || count !== CW'(1) ||
                dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL wrap_frame[%0d]: tx_start=%b tx_data=%h count=%0d, expected 1 %h 1",
                         k, tx_start, tx_data, count, want);
            end
            step();
        end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        want = sb.pop_front();
        checks++;
        if (tx_start !== 1'b1 || tx_data !== want || empty !== 1'b1) begin
            errors++;
            $display("FAIL wrap_last: tx_start=%b tx_data=%h empty=%b, expected 1 %h 1",
                     tx_start, tx_data, empty, want);
        end
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || empty !== 1'b1 || sb.size() != 0) begin
            errors++;
            $display("FAIL wrap_end: busy=%b empty=%b left=%0d, expected 0 1 0",
                     busy, empty, sb.size());
        end
    endtask

    // Flush with 5 stored words and a frame in flight, plus flush+write.
    task automatic test_flush();
        logic [DATA_LEN-1:0] first;
        first = DATA_LEN'($urandom);
        for (int i = 0; i < 6; i++) begin
            wr_en   = 1'b1;
            wr_data = (i == 0) ? first : DATA_LEN'($urandom);
            step();
        end
        wr_en = 1'b0;
        checks++;
        if (count !== CW'(5) || tx_data !== first || busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_setup: count=%0d tx_data=%h busy=%b, expected 5 %h 1",
                     count, tx_data, busy, first);
        end
        flush = 1'b1; wr_en = 1'b1; wr_data = 8'h3C;
        step();
        flush = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (count !== CW'(0) || empty !== 1'b1 || tx_data !== first || busy !== 1'b1 ||
                tx_start !== 1'b0 || dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL flush_hold: got %h, expected %h", dut_vec(), exp_vec());
            end
            step();
        end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || tx_start !== 1'b0 || empty !== 1'b1 || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL flush_done: got %h, expected %h", dut_vec(), exp_vec());
        end
    endtask

    // Asynchronous reset in the middle of a frame, then a stray tx_done.
    task automatic test_reset_midframe();
        wr_en = 1'b1; wr_data = 8'h5A;
        step();
        wr_data = 8'hC3;
        step();
        wr_en = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({empty, count, tx_start, tx_data, busy, full, overflow} !==
            {1'b1, CW'(0), 1'b0, DATA_LEN'(0), 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_async: got %h, expected reset values", dut_vec());
        end
        step();
        rst = 1'b1;
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (tx_start !== 1'b0 || busy !== 1'b0 || dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_stray_done: got %h, expected %h", dut_vec(), exp_vec());
            end
            step();
        end
    endtask

    // Random traffic against the model, every cycle compared.
    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            wr_en   = ($urandom_range(0, 99) < 45);
            wr_data = DATA_LEN'($urandom);
            flush   = ($urandom_range(0, 99) < 2);
            tx_done = ($urandom_range(0, 99) < 20);
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random[%0d]: got %h, expected %h", i, dut_vec(), exp_vec());
            end
        end
        wr_en = 1'b0; flush = 1'b0; tx_done = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_single_word();
        test_burst();
        test_overflow();
        test_drain();
        test_wrap();
        test_flush();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
